// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, accepts out-of-order CDB results,
// retires one entry per cycle from head and raises a flush pulse on a mispredicted head branch.
module reorder_buffer #(
  parameter int ROB_SZ   = 16,
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int REG_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rdy,
  input  logic                i_issue_valid,
  input  logic                i_issue_has_rd,
  input  logic [REG_ID_W-1:0] i_issue_rd,
  input  logic                i_issue_is_br,
  input  logic                i_issue_pred,
  input  logic [DATA_W-1:0]   i_issue_alt_pc,
  output logic [ROB_ID_W-1:0] o_issue_rob_id,
  output logic                o_rob_full,
  input  logic                i_wb_valid,
  input  logic [ROB_ID_W-1:0] i_wb_rob_id,
  input  logic [DATA_W-1:0]   i_wb_data,
  input  logic                i_wb_taken,
  input  logic [ROB_ID_W-1:0] i_q1_rob_id,
  output logic                o_q1_ready,
  output logic [DATA_W-1:0]   o_q1_data,
  input  logic [ROB_ID_W-1:0] i_q2_rob_id,
  output logic                o_q2_ready,
  output logic [DATA_W-1:0]   o_q2_data,
  output logic                o_is_commit,
  output logic [REG_ID_W-1:0] o_commit_rd,
  output logic [DATA_W-1:0]   o_commit_data,
  output logic [ROB_ID_W-1:0] o_commit_rob_id,
  output logic                o_rollback,
  output logic [DATA_W-1:0]   o_rollback_pc
);

  localparam logic [ROB_ID_W:0]   C_CNT_FULL = (ROB_ID_W+1)'(ROB_SZ);
  localparam logic [ROB_ID_W:0]   C_CNT_ONE  = (ROB_ID_W+1)'(1);
  localparam logic [ROB_ID_W-1:0] C_ID_ONE   = ROB_ID_W'(1);

  logic [ROB_SZ-1:0]   r_valid;
  logic [ROB_SZ-1:0]   r_ready;
  logic [ROB_SZ-1:0]   r_has_rd;
  logic [ROB_SZ-1:0]   r_is_br;
  logic [ROB_SZ-1:0]   r_pred;
  logic [ROB_SZ-1:0]   r_taken;
  logic [REG_ID_W-1:0] r_rd     [ROB_SZ];
  logic [DATA_W-1:0]   r_data   [ROB_SZ];
  logic [DATA_W-1:0]   r_alt_pc [ROB_SZ];

  logic [ROB_ID_W-1:0] r_head;
  logic [ROB_ID_W-1:0] r_tail;
  logic [ROB_ID_W:0]   r_count;

  logic                r_is_commit;
  logic [REG_ID_W-1:0] r_commit_rd;
  logic [DATA_W-1:0]   r_commit_data;
  logic [ROB_ID_W-1:0] r_commit_rob_id;
  logic                r_rollback;
  logic [DATA_W-1:0]   r_rollback_pc;

  logic                w_full;
  logic                w_issue_acc;
  logic                w_wb_acc;
  logic                w_head_rdy;
  logic                w_mispred;
  logic                w_commit;
  logic [ROB_ID_W:0]   w_count_nxt;
  logic                w_q1_fwd;
  logic                w_q2_fwd;

  assign w_full      = (r_count == C_CNT_FULL);
  assign w_issue_acc = i_issue_valid & ~w_full & ~r_rollback;
  assign w_wb_acc    = i_wb_valid & r_valid[i_wb_rob_id] & ~r_rollback;

  // Head retires only on registered ready; a flush cycle blocks retirement entirely.
  assign w_head_rdy = r_valid[r_head] & r_ready[r_head] & ~r_rollback;
  assign w_mispred  = w_head_rdy & r_is_br[r_head] & (r_taken[r_head] != r_pred[r_head]);
  assign w_commit   = w_head_rdy & ~w_mispred;

  assign w_q1_fwd   = i_wb_valid & (i_wb_rob_id == i_q1_rob_id) & r_valid[i_q1_rob_id];
  assign w_q2_fwd   = i_wb_valid & (i_wb_rob_id == i_q2_rob_id) & r_valid[i_q2_rob_id];
  assign o_q1_ready = r_ready[i_q1_rob_id] | w_q1_fwd;
  assign o_q1_data  = w_q1_fwd ? i_wb_data : r_data[i_q1_rob_id];
  assign o_q2_ready = r_ready[i_q2_rob_id] | w_q2_fwd;
  assign o_q2_data  = w_q2_fwd ? i_wb_data : r_data[i_q2_rob_id];

  assign o_issue_rob_id  = r_tail;
  assign o_rob_full      = w_full;
  assign o_is_commit     = r_is_commit;
  assign o_commit_rd     = r_commit_rd;
  assign o_commit_data   = r_commit_data;
  assign o_commit_rob_id = r_commit_rob_id;
  assign o_rollback      = r_rollback;
  assign o_rollback_pc   = r_rollback_pc;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_issue_acc, w_commit})
      2'b10:   w_count_nxt = r_count + C_CNT_ONE;
      2'b01:   w_count_nxt = r_count - C_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid         <= '0;
      r_ready         <= '0;
      r_has_rd        <= '0;
      r_is_br         <= '0;
      r_pred          <= '0;
      r_taken         <= '0;
      for (int i = 0; i < ROB_SZ; i++) begin
        r_rd[i]     <= '0;
        r_data[i]   <= '0;
        r_alt_pc[i] <= '0;
      end
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_is_commit     <= 1'b0;
      r_commit_rd     <= '0;
      r_commit_data   <= '0;
      r_commit_rob_id <= '0;
      r_rollback      <= 1'b0;
      r_rollback_pc   <= '0;
    end else if (i_rdy) begin
      if (r_rollback) begin
        r_valid     <= '0;
        r_ready     <= '0;
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
        r_rollback  <= 1'b0;
        r_is_commit <= 1'b0;
      end else begin
        if (w_wb_acc) begin
          r_ready[i_wb_rob_id] <= 1'b1;
          r_data[i_wb_rob_id]  <= i_wb_data;
          r_taken[i_wb_rob_id] <= i_wb_taken;
        end
        if (w_issue_acc) begin
          r_valid[r_tail]  <= 1'b1;
          r_ready[r_tail]  <= 1'b0;
          r_has_rd[r_tail] <= i_issue_has_rd;
          r_rd[r_tail]     <= i_issue_rd;
          r_is_br[r_tail]  <= i_issue_is_br;
          r_pred[r_tail]   <= i_issue_pred;
          r_alt_pc[r_tail] <= i_issue_alt_pc;
          r_tail           <= r_tail + C_ID_ONE;
        end
        r_count     <= w_count_nxt;
        r_rollback  <= w_mispred;
        r_is_commit <= w_commit & r_has_rd[r_head] & ~r_is_br[r_head];
        if (w_mispred) begin
          r_rollback_pc <= r_alt_pc[r_head];
        end
        // Clearing the head is placed last so it overrides a same-cycle writeback to it.
        if (w_commit) begin
          r_commit_rd     <= r_rd[r_head];
          r_commit_data   <= r_data[r_head];
          r_commit_rob_id <= r_head;
          r_valid[r_head] <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + C_ID_ONE;
        end
      end
    end
  end

endmodule
